icache_assoc: RTL and testbench
===============================

// Module: icache_assoc
// PURPOSE
//  Parametrised set-associative, multi-word-block instruction cache between the fetch stage and the memory arbiter.
//  Same-cycle hit path to the datapath; on a miss, a refill FSM fetches one whole block word-by-word.
//  Supports LRU replacement, a global flush, and saturating hit/miss counters.
// PARAMETERS
//  SETS         8   number of sets, power of 2, >=2
//  WAYS         2   associativity, 1 or 2 (1 = direct mapped, LRU unused)
//  BLOCK_WORDS  2   32-bit words per block, power of 2, >=1
//  CNT_W        32  width of the hit/miss counters
// PORTS
//  CLK          in   1      clock
//  nRST         in   1      reset, asynchronous, active-low
//  imemREN      in   1      datapath fetch request
//  imemaddr     in   32     fetch byte address (word aligned)
//  ihit         out  1      imemload is valid this cycle
//  imemload     out  32     instruction word
//  iflush       in   1      invalidate entire cache (1-cycle pulse)
//  iREN         out  1      memory read request
//  iaddr        out  32     memory read word address
//  iwait        in   1      memory busy; iload valid when iREN && !iwait
//  iload        in   32     memory read data
//  hit_cnt      out  CNT_W  lookups that hit
//  miss_cnt     out  CNT_W  misses started
// BEHAVIOUR
//  Address split: [1:0] byte (ignored), then BOFF=log2(BLOCK_WORDS), IDX=log2(SETS), remainder = TAG.
//  Reset: all valid=0, LRU=0, state IDLE, counters 0, fill regs 0; ihit=0, iREN=0, iaddr=0, imemload=0.
//  IDLE lookup (combinational): hit = imemREN && some way valid && tag match.
//   ihit=1, imemload=way[hit].data[BOFF], iREN=0. On the clock edge, LRU[idx] points at the other way and hit_cnt++.
//  IDLE miss (imemREN && !hit): latch {tag,idx} and set word counter wc=0; go to FILL.
//   miss_cnt++ and ihit=0 in this cycle.
//  FILL: iREN=1, iaddr={tag,idx,wc,2'b00}, ihit=0.
//   Each cycle with !iwait: write iload into the victim way's data[wc] and increment wc.
//   When wc==BLOCK_WORDS-1 and !iwait: write tag, set valid, update LRU to the other way, go to IDLE.
//   The next cycle re-looks-up and hits, so best-case miss latency is BLOCK_WORDS+1 cycles.
//  Victim selection: the first invalid way (way0 first); otherwise the way LRU[idx] points at. Latched at the FILL start.
//  Partial blocks never hit: valid is set only on the last word.
//   The victim's valid bit is cleared at FILL start, so a stale tag cannot hit.
//  imemaddr change or imemREN drop during FILL: the fill still completes with the latched address. No abort.
//  iflush: clears all valid bits and LRU in one edge.
//   In FILL it aborts the fill: back to IDLE, iREN=0 the next cycle, no block installed.
//   Flush has priority over fill completion in the same cycle.
//  imemREN=0 in IDLE: ihit=0, iREN=0, counters hold.
//  Counters saturate at all-ones (no wrap). A flush does not clear the counters.
//  Reset mid-FILL: immediate return to the reset state, including iREN=0.
// STRUCTURE
//  cpu_types_pkg: icache_fsm_t enum {IDLE, FILL}; word_t; ICACHE_* default constants.
//  Field-extraction helper localparams are derived from the parameters.
//  Sub-module icache_way: holds one way's valid, tag and data arrays.
//   Asynchronous read by idx; synchronous write of a word, and of tag+valid; flush clears valid.
//   It is instantiated WAYS times. The LRU bits, FSM and counters live in the top module.
// TESTING (defaults, iwait=0 unless stated)
//  Cold miss at addr 0x100:
//   -> iREN=1 with iaddr 0x100 then 0x104; ihit in cycle 3 with data M[0x100]; miss_cnt=1.
//  Next fetch at 0x104 after the fill -> ihit=1 the same cycle, iREN=0, hit_cnt increments.
//  Conflict with 3 tags in one set (0x000, 0x040, 0x080), then 0x000:
//   -> 0x040 is evicted (LRU); 0x000 still hits; 0x040 misses again.
//  iwait=1 for 3 cycles on each word -> iaddr holds, no data array write until !iwait; final data correct.
//  iflush in the cycle the last word returns:
//   -> no block installed, state IDLE, the re-fetch misses; the counters are not cleared.
//  Branch mid-FILL: imemaddr changes to 0x200 -> the old block completes, then 0x200 misses and fills.
//  Assert nRST mid-FILL -> iREN=0 and ihit=0 immediately; all lines invalid.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types and default sizing for the instruction cache and its neighbours.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } icache_fsm_t;

   localparam int ICACHE_SETS        = 8;
   localparam int ICACHE_WAYS        = 2;
   localparam int ICACHE_BLOCK_WORDS = 2;
   localparam int ICACHE_CNT_W       = 32;

   // Bit width needed to index n items, never less than one bit so ports stay legal.
   function automatic int clog2Min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/icache_way.sv
// One way of the instruction cache: valid bits, tags and block data for every set.
// Reads are asynchronous so the lookup completes in the request cycle.
module icache_way
   import cpu_types_pkg::*;
#(
   parameter int SETS        = ICACHE_SETS,
   parameter int BLOCK_WORDS = ICACHE_BLOCK_WORDS,
   parameter int IDX_W       = 3,
   parameter int OFF_W       = 1,
   parameter int TAG_W       = 26
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [IDX_W-1:0] rdIdx_i,
   input  logic [OFF_W-1:0] rdOff_i,
   output logic             rdValid_o,
   output logic [TAG_W-1:0] rdTag_o,
   output word_t            rdData_o,
   input  logic [IDX_W-1:0] wrIdx_i,
   input  logic             wordWrEn_i,
   input  logic [OFF_W-1:0] wrOff_i,
   input  word_t            wrData_i,
   input  logic             tagWrEn_i,
   input  logic [TAG_W-1:0] wrTag_i,
   input  logic             invEn_i,
   input  logic             flush_i
);

   logic [SETS-1:0]  valid_q;
   logic [TAG_W-1:0] tag_q  [SETS];
   word_t            data_q [SETS][BLOCK_WORDS];

   assign rdValid_o = valid_q[rdIdx_i];
   assign rdTag_o   = tag_q[rdIdx_i];
   assign rdData_o  = data_q[rdIdx_i][rdOff_i];

   // Valid and tag state; a flush wins over any install so a flushed fill never appears.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid_q <= '0;
         for (int s = 0; s < SETS; s++) begin
            tag_q[s] <= '0;
         end
      end else if (flush_i) begin
         valid_q <= '0;
      end else begin
         if (invEn_i) begin
            valid_q[wrIdx_i] <= 1'b0;
         end
         if (tagWrEn_i) begin
            valid_q[wrIdx_i] <= 1'b1;
            tag_q[wrIdx_i]   <= wrTag_i;
         end
      end
   end

   // Block data is plain storage; its contents only matter once the line is valid.
   always_ff @(posedge CLK) begin
      if (wordWrEn_i) begin
         data_q[wrIdx_i][wrOff_i] <= wrData_i;
      end
   end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative multi-word-block instruction cache between fetch and the memory arbiter.
// Hits are answered combinationally; misses refill a whole block word by word.
module icache_assoc
   import cpu_types_pkg::*;
#(
   parameter int SETS        = ICACHE_SETS,
   parameter int WAYS        = ICACHE_WAYS,
   parameter int BLOCK_WORDS = ICACHE_BLOCK_WORDS,
   parameter int CNT_W       = ICACHE_CNT_W
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             imemREN,
   input  logic [31:0]      imemaddr,
   output logic             ihit,
   output logic [31:0]      imemload,
   input  logic             iflush,
   output logic             iREN,
   output logic [31:0]      iaddr,
   input  logic             iwait,
   input  logic [31:0]      iload,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   localparam int BOFF  = $clog2(BLOCK_WORDS);
   localparam int OFF_W = clog2Min1(BLOCK_WORDS);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 30 - BOFF - IDX_W;
   localparam int WAY_W = clog2Min1(WAYS);
   localparam logic [OFF_W-1:0] LAST_WC = OFF_W'(BLOCK_WORDS - 1);

   icache_fsm_t      state_q;
   logic [TAG_W-1:0] fillTag_q;
   logic [IDX_W-1:0] fillIdx_q;
   logic [OFF_W-1:0] wc_q;
   logic [WAY_W-1:0] victim_q;
   logic [SETS-1:0]  lru_q;
   logic [CNT_W-1:0] hitCnt_q;
   logic [CNT_W-1:0] missCnt_q;

   logic [TAG_W-1:0] reqTag;
   logic [IDX_W-1:0] reqIdx;
   logic [OFF_W-1:0] reqOff;

   logic [WAYS-1:0]  wayValid;
   logic [TAG_W-1:0] wayTag  [WAYS];
   word_t            wayData [WAYS];

   logic             lookupHit;
   logic [WAY_W-1:0] hitWay;
   word_t            hitData;
   logic [WAY_W-1:0] victimSel;
   logic             foundInvalid;

   logic             fillWord;
   logic             lastWord;
   logic             missStart;
   logic             hitEvent;
   logic [IDX_W-1:0] wrIdx;
   logic [WAYS-1:0]  wordWrEn;
   logic [WAYS-1:0]  tagWrEn;
   logic [WAYS-1:0]  invEn;
   word_t            fillAddr;

   assign reqOff = OFF_W'((imemaddr >> 2) & word_t'(BLOCK_WORDS - 1));
   assign reqIdx = IDX_W'((imemaddr >> (2 + BOFF)) & word_t'(SETS - 1));
   assign reqTag = TAG_W'(imemaddr >> (2 + BOFF + IDX_W));

   // Tag compare across all ways; at most one way can match a given tag.
   always_comb begin
      lookupHit = 1'b0;
      hitWay    = '0;
      hitData   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (wayValid[w] && (wayTag[w] == reqTag)) begin
            lookupHit = 1'b1;
            hitWay    = WAY_W'(w);
            hitData   = wayData[w];
         end
      end
   end

   // Replacement choice: lowest-numbered invalid way, else the way the LRU bit names.
   always_comb begin
      victimSel    = '0;
      foundInvalid = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!wayValid[w] && !foundInvalid) begin
            victimSel    = WAY_W'(w);
            foundInvalid = 1'b1;
         end
      end
      if (!foundInvalid && (WAYS > 1)) begin
         victimSel = WAY_W'(lru_q[reqIdx]);
      end
   end

   assign hitEvent  = (state_q == IDLE) && imemREN && lookupHit;
   assign missStart = (state_q == IDLE) && imemREN && !lookupHit && !iflush;
   assign fillWord  = (state_q == FILL) && !iwait && !iflush;
   assign lastWord  = fillWord && (wc_q == LAST_WC);
   assign wrIdx     = (state_q == IDLE) ? reqIdx : fillIdx_q;

   // Per-way write strobes: invalidate the victim at miss time, fill it word by word, install on the last word.
   always_comb begin
      wordWrEn = '0;
      tagWrEn  = '0;
      invEn    = '0;
      for (int w = 0; w < WAYS; w++) begin
         wordWrEn[w] = fillWord  && (victim_q  == WAY_W'(w));
         tagWrEn[w]  = lastWord  && (victim_q  == WAY_W'(w));
         invEn[w]    = missStart && (victimSel == WAY_W'(w));
      end
   end

   for (genvar g = 0; g < WAYS; g++) begin : gWay
      icache_way #(
         .SETS        (SETS),
         .BLOCK_WORDS (BLOCK_WORDS),
         .IDX_W       (IDX_W),
         .OFF_W       (OFF_W),
         .TAG_W       (TAG_W)
      ) uWay (
         .CLK        (CLK),
         .nRST       (nRST),
         .rdIdx_i    (reqIdx),
         .rdOff_i    (reqOff),
         .rdValid_o  (wayValid[g]),
         .rdTag_o    (wayTag[g]),
         .rdData_o   (wayData[g]),
         .wrIdx_i    (wrIdx),
         .wordWrEn_i (wordWrEn[g]),
         .wrOff_i    (wc_q),
         .wrData_i   (iload),
         .tagWrEn_i  (tagWrEn[g]),
         .wrTag_i    (fillTag_q),
         .invEn_i    (invEn[g]),
         .flush_i    (iflush)
      );
   end

   // Refill word address rebuilt from the latched tag, set and word counter.
   always_comb begin
      fillAddr = (word_t'(fillTag_q) << (2 + BOFF + IDX_W))
               | (word_t'(fillIdx_q) << (2 + BOFF))
               | (word_t'(wc_q) << 2);
   end

   assign ihit     = hitEvent;
   assign imemload = hitEvent ? hitData : '0;
   assign iREN     = (state_q == FILL);
   assign iaddr    = (state_q == FILL) ? fillAddr : '0;
   assign hit_cnt  = hitCnt_q;
   assign miss_cnt = missCnt_q;

   // Refill controller and LRU bits; a flush aborts any fill and clears LRU in the same edge.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= IDLE;
         fillTag_q <= '0;
         fillIdx_q <= '0;
         wc_q      <= '0;
         victim_q  <= '0;
         lru_q     <= '0;
      end else if (iflush) begin
         state_q <= IDLE;
         lru_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (imemREN) begin
                  if (lookupHit) begin
                     lru_q[reqIdx] <= (hitWay == '0);
                  end else begin
                     fillTag_q <= reqTag;
                     fillIdx_q <= reqIdx;
                     wc_q      <= '0;
                     victim_q  <= victimSel;
                     state_q   <= FILL;
                  end
               end
            end
            FILL: begin
               if (!iwait) begin
                  if (wc_q == LAST_WC) begin
                     lru_q[fillIdx_q] <= (victim_q == '0);
                     state_q          <= IDLE;
                  end else begin
                     wc_q <= wc_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Saturating statistics; flushes leave them alone, only reset clears them.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hitCnt_q  <= '0;
         missCnt_q <= '0;
      end else begin
         if (hitEvent && (hitCnt_q != '1)) begin
            hitCnt_q <= hitCnt_q + 1'b1;
         end
         if (missStart && (missCnt_q != '1)) begin
            missCnt_q <= missCnt_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_icache_assoc.sv
// Self-checking bench for icache_assoc: directed scenarios plus random fetches
// compared against a recency-list model of the cache contents.
module tb_icache_assoc;
   import cpu_types_pkg::*;

   localparam int SETS  = 8;
   localparam int WAYS  = 2;
   localparam int BW    = 2;
   localparam int CNT_W = 32;
   localparam int BOFF  = $clog2(BW);
   localparam int IDXW  = $clog2(SETS);

   logic             CLK = 1'b0;
   logic             nRST = 1'b0;
   logic             imemREN = 1'b0;
   logic [31:0]      imemaddr = '0;
   logic             ihit;
   logic [31:0]      imemload;
   logic             iflush = 1'b0;
   logic             iREN;
   logic [31:0]      iaddr;
   logic             iwait = 1'b0;
   logic [31:0]      iload = '0;
   logic [CNT_W-1:0] hit_cnt;
   logic [CNT_W-1:0] miss_cnt;

   int tests = 0;
   int fails = 0;

   // Model: per set, resident tags ordered least- to most-recently used.
   int unsigned      mTag [SETS][WAYS];
   int               mCnt [SETS];
   logic [CNT_W-1:0] expHit = '0;
   logic [CNT_W-1:0] expMiss = '0;

   icache_assoc #(
      .SETS        (SETS),
      .WAYS        (WAYS),
      .BLOCK_WORDS (BW),
      .CNT_W       (CNT_W)
   ) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .imemREN  (imemREN),
      .imemaddr (imemaddr),
      .ihit     (ihit),
      .imemload (imemload),
      .iflush   (iflush),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload),
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt)
   );

   // Free-running clock.
   always #5 CLK = ~CLK;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   function automatic int setOf(input logic [31:0] a);
      return int'((a >> (2 + BOFF)) % SETS);
   endfunction

   function automatic int unsigned tagOf(input logic [31:0] a);
      return int'(a >> (2 + BOFF + IDXW));
   endfunction

   function automatic logic [31:0] baseOf(input logic [31:0] a);
      return a & ~32'(BW * 4 - 1);
   endfunction

   function automatic int modelFind(input int s, input int unsigned t);
      for (int i = 0; i < mCnt[s]; i++) begin
         if (mTag[s][i] == t) return i;
      end
      return -1;
   endfunction

   function automatic void modelTouch(input int s, input int p);
      int unsigned tmp;
      tmp = mTag[s][p];
      for (int i = p; i < mCnt[s] - 1; i++) mTag[s][i] = mTag[s][i + 1];
      mTag[s][mCnt[s] - 1] = tmp;
   endfunction

   function automatic void modelEvict(input int s);
      if (mCnt[s] == WAYS) begin
         for (int i = 0; i < WAYS - 1; i++) mTag[s][i] = mTag[s][i + 1];
         mCnt[s] = mCnt[s] - 1;
      end
   endfunction

   function automatic void modelInsert(input int s, input int unsigned t);
      mTag[s][mCnt[s]] = t;
      mCnt[s] = mCnt[s] + 1;
   endfunction

   function automatic void modelFlush();
      for (int s = 0; s < SETS; s++) mCnt[s] = 0;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One fetch of addr; on a miss, serve the refill. waitMode 0 none, 1 three waits per word,
   // 2 random. flushAt >= 0 pulses iflush with that word. doBranch redirects imemaddr during the fill.
   task automatic applyStimulus(input logic [31:0] addr, input int waitMode, input int flushAt,
                                input logic doBranch, input logic [31:0] brAddr);
      int s;
      int unsigned t;
      int pos;
      logic [31:0] base;
      int wc;
      int cyc;
      int waits;
      logic w;
      logic aborted;
      s    = setOf(addr);
      t    = tagOf(addr);
      base = baseOf(addr);
      pos  = modelFind(s, t);
      @(posedge CLK); #1;
      imemREN = 1'b1; imemaddr = addr; iwait = 1'b0; iflush = 1'b0;
      @(negedge CLK);
      checkOutput("ihit lookup", 32'(ihit), 32'(pos >= 0));
      checkOutput("iREN lookup", 32'(iREN), 32'd0);
      if (pos >= 0) begin
         checkOutput("imemload hit", imemload, memWord(addr));
         modelTouch(s, pos);
         if (expHit != '1) expHit++;
      end else begin
         if (expMiss != '1) expMiss++;
         modelEvict(s);
         wc = 0; cyc = 0; waits = 0; aborted = 1'b0;
         while (wc < BW && !aborted && cyc < 100) begin
            @(posedge CLK); #1;
            if (doBranch) imemaddr = brAddr;
            if (waitMode == 1)      w = (waits < 3);
            else if (waitMode == 2) w = ($urandom_range(0, 2) == 0);
            else                    w = 1'b0;
            if (flushAt == wc) w = 1'b0;
            iwait  = w;
            iflush = (flushAt == wc);
            iload  = w ? $urandom : memWord(base + 32'(wc * 4));
            @(negedge CLK);
            checkOutput("iREN fill", 32'(iREN), 32'd1);
            checkOutput("iaddr fill", iaddr, base + 32'(wc * 4));
            checkOutput("ihit fill", 32'(ihit), 32'd0);
            if (iflush) aborted = 1'b1;
            else if (w) waits++;
            else begin
               wc++;
               waits = 0;
            end
            cyc++;
         end
         if (cyc >= 100) begin
            tests++;
            fails++;
            $error("[TB] FAIL fill bound observed=%0d cycles expected=fill completion", cyc);
         end
         if (aborted) begin
            modelFlush();
            @(posedge CLK); #1;
            iflush = 1'b0; imemREN = 1'b0; iwait = 1'b0;
            @(negedge CLK);
            checkOutput("iREN after abort", 32'(iREN), 32'd0);
            checkOutput("ihit after abort", 32'(ihit), 32'd0);
         end else begin
            modelInsert(s, t);
         end
      end
   endtask

   task automatic checkCounters();
      @(posedge CLK); #1;
      imemREN = 1'b0; iflush = 1'b0; iwait = 1'b0;
      @(negedge CLK);
      checkOutput("ihit idle", 32'(ihit), 32'd0);
      checkOutput("iREN idle", 32'(iREN), 32'd0);
      checkOutput("hit_cnt", hit_cnt, expHit);
      checkOutput("miss_cnt", miss_cnt, expMiss);
   endtask

   task automatic doFlush();
      @(posedge CLK); #1;
      imemREN = 1'b0; iwait = 1'b0; iflush = 1'b1;
      @(posedge CLK); #1;
      iflush = 1'b0;
      modelFlush();
   endtask

   // Directed scenarios, a random phase, then reset during a refill.
   initial begin
      logic [31:0] a;
      modelFlush();
      #2;
      checkOutput("reset ihit", 32'(ihit), 32'd0);
      checkOutput("reset iREN", 32'(iREN), 32'd0);
      checkOutput("reset iaddr", iaddr, 32'd0);
      checkOutput("reset imemload", imemload, 32'd0);
      checkOutput("reset hit_cnt", hit_cnt, 32'd0);
      checkOutput("reset miss_cnt", miss_cnt, 32'd0);
      #5 nRST = 1'b1;

      $display("[TB] cold miss and same-block hits");
      applyStimulus(32'h100, 0, -1, 1'b0, 32'h0);
      applyStimulus(32'h100, 0, -1, 1'b0, 32'h0);
      applyStimulus(32'h104, 0, -1, 1'b0, 32'h0);
      checkCounters();
      checkOutput("cold miss count", miss_cnt, 32'd1);

      $display("[TB] three-tag conflict in one set");
      applyStimulus(32'h000, 0, -1, 1'b0, 32'h0);
      applyStimulus(32'h040, 0, -1, 1'b0, 32'h0);
      applyStimulus(32'h000, 0, -1, 1'b0, 32'h0);
      applyStimulus(32'h080, 0, -1, 1'b0, 32'h0);
      applyStimulus(32'h080, 0, -1, 1'b0, 32'h0);
      applyStimulus(32'h000, 0, -1, 1'b0, 32'h0);
      applyStimulus(32'h040, 0, -1, 1'b0, 32'h0);
      applyStimulus(32'h040, 0, -1, 1'b0, 32'h0);
      checkCounters();

      $display("[TB] refill with memory wait states");
      applyStimulus(32'h180, 1, -1, 1'b0, 32'h0);
      applyStimulus(32'h180, 0, -1, 1'b0, 32'h0);
      applyStimulus(32'h184, 0, -1, 1'b0, 32'h0);
      checkCounters();

      $display("[TB] flush on the last refill word");
      applyStimulus(32'h1C0, 0, BW - 1, 1'b0, 32'h0);
      applyStimulus(32'h1C0, 0, -1, 1'b0, 32'h0);
      applyStimulus(32'h1C4, 0, -1, 1'b0, 32'h0);
      checkCounters();

      $display("[TB] branch during a refill");
      applyStimulus(32'h140, 0, -1, 1'b1, 32'h200);
      applyStimulus(32'h200, 0, -1, 1'b0, 32'h0);
      applyStimulus(32'h204, 0, -1, 1'b0, 32'h0);
      applyStimulus(32'h144, 0, -1, 1'b0, 32'h0);
      checkCounters();

      $display("[TB] random fetch stream");
      for (int i = 0; i < 60; i++) begin
         a = (32'($urandom_range(0, 5)) << 6) | (32'($urandom_range(0, 3)) << 3)
           | (32'($urandom_range(0, 1)) << 2);
         if ($urandom_range(0, 14) == 0) doFlush();
         applyStimulus(a, 2, -1, 1'b0, 32'h0);
      end
      checkCounters();

      $display("[TB] reset during a refill");
      doFlush();
      @(posedge CLK); #1;
      imemREN = 1'b1; imemaddr = 32'h300; iwait = 1'b0;
      @(posedge CLK); #1;
      iwait = 1'b1;
      @(negedge CLK);
      checkOutput("iREN before reset", 32'(iREN), 32'd1);
      nRST = 1'b0;
      #1;
      checkOutput("iREN in reset", 32'(iREN), 32'd0);
      checkOutput("ihit in reset", 32'(ihit), 32'd0);
      checkOutput("hit_cnt in reset", hit_cnt, 32'd0);
      checkOutput("miss_cnt in reset", miss_cnt, 32'd0);
      @(posedge CLK); #1;
      nRST = 1'b1; imemREN = 1'b0; iwait = 1'b0;
      modelFlush();
      expHit = '0;
      expMiss = '0;
      applyStimulus(32'h100, 0, -1, 1'b0, 32'h0);
      applyStimulus(32'h100, 0, -1, 1'b0, 32'h0);
      checkCounters();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
